// File: rtl/mode_scan_ctrl.sv
// Sweeps every (x,y) operand pair through the shared packing datapath and
// streams the results over a 1-deep valid/ready register with a running checksum.
module mode_scan_ctrl #(
    parameter int OPW  = 3,
    parameter int AW   = 8,
    parameter int SUMW = 12
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            mode,
    input  logic            abort,
    output logic [OPW-1:0]  op_x,
    output logic [OPW-1:0]  op_y,
    input  logic [AW-1:0]   ans0_in,
    input  logic [AW-1:0]   ans1_in,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [AW-1:0]   res_data,
    output logic [OPW-1:0]  res_x,
    output logic [OPW-1:0]  res_y,
    output logic            busy,
    output logic            done,
    output logic [SUMW-1:0] checksum
);

    localparam int IW = 2 * OPW;
    localparam logic [IW-1:0] LAST = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t          r_state;
    logic            r_mode;
    logic [IW-1:0]   r_idx;
    logic            r_res_valid;
    logic [AW-1:0]   r_res_data;
    logic [OPW-1:0]  r_res_x;
    logic [OPW-1:0]  r_res_y;
    logic            r_done;
    logic [SUMW-1:0] r_sum;

    state_t          w_state;
    logic            w_mode;
    logic [IW-1:0]   w_idx;
    logic            w_res_valid;
    logic [AW-1:0]   w_res_data;
    logic [OPW-1:0]  w_res_x;
    logic [OPW-1:0]  w_res_y;
    logic            w_done;
    logic [SUMW-1:0] w_sum;
    logic            w_load;
    logic            w_accept;
    logic [SUMW-1:0] w_sum_add;

    assign w_load    = !r_res_valid || res_ready;
    assign w_accept  = r_res_valid && res_ready;
    assign w_sum_add = r_sum + {{(SUMW-AW){1'b0}}, r_res_data};

    always_comb begin
        w_state     = r_state;
        w_mode      = r_mode;
        w_idx       = r_idx;
        w_res_valid = r_res_valid;
        w_res_data  = r_res_data;
        w_res_x     = r_res_x;
        w_res_y     = r_res_y;
        w_done      = 1'b0;
        w_sum       = r_sum;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_mode      = mode;
                    w_idx       = '0;
                    w_sum       = '0;
                    w_res_valid = 1'b0;
                    w_state     = S_RUN;
                end
            end
            S_RUN: begin
                // abort outranks both the load and any accept at this edge
                if (abort) begin
                    w_res_valid = 1'b0;
                    w_state     = S_IDLE;
                end else begin
                    if (w_accept) w_sum = w_sum_add;
                    if (w_load) begin
                        w_res_data  = r_mode ? ans1_in : ans0_in;
                        w_res_x     = r_idx[IW-1:OPW];
                        w_res_y     = r_idx[OPW-1:0];
                        w_res_valid = 1'b1;
                        if (r_idx == LAST) w_state = S_DRAIN;
                        else               w_idx   = r_idx + IW'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (abort) begin
                    w_res_valid = 1'b0;
                    w_state     = S_IDLE;
                end else if (w_accept) begin
                    w_sum       = w_sum_add;
                    w_res_valid = 1'b0;
                    w_done      = 1'b1;
                    w_state     = S_IDLE;
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_mode      <= 1'b0;
            r_idx       <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_x     <= '0;
            r_res_y     <= '0;
            r_done      <= 1'b0;
            r_sum       <= '0;
        end else begin
            r_state     <= w_state;
            r_mode      <= w_mode;
            r_idx       <= w_idx;
            r_res_valid <= w_res_valid;
            r_res_data  <= w_res_data;
            r_res_x     <= w_res_x;
            r_res_y     <= w_res_y;
            r_done      <= w_done;
            r_sum       <= w_sum;
        end
    end

    assign op_x      = r_idx[IW-1:OPW];
    assign op_y      = r_idx[OPW-1:0];
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_x     = r_res_x;
    assign res_y     = r_res_y;
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign checksum  = r_sum;

endmodule
